// File: rtl/cq_burst_reader_if.sv
// cq_burst_reader_if: groups the circular-queue read port and the outgoing
// byte stream of the burst reader.
// Stream handshake: a byte moves when dout_valid & dout_ready are both high on
// a rising clock edge; once dout_valid is high, dout and dout_valid stay
// stable until that handshake happens.
interface cq_burst_reader_if #(
    parameter int DW = 8
);
    logic          q_empty;
    logic [DW-1:0] q_data;
    logic          q_pop;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;

    // Reader side: drives the pop strobe and the stream.
    modport master (
        input  q_empty,
        input  q_data,
        input  dout_ready,
        output q_pop,
        output dout,
        output dout_valid
    );

    // Environment side: the queue and the downstream consumer.
    modport slave (
        output q_empty,
        output q_data,
        output dout_ready,
        input  q_pop,
        input  dout,
        input  dout_valid
    );
endinterface

// File: rtl/cq_burst_reader.sv
// cq_burst_reader: on rd_start pops a burst of 1..2^CW bytes from the circular
// queue and streams them out through a 2-entry skid buffer. Queue read data
// lands one cycle after the pop, so pops are issued only while a buffer slot
// is guaranteed free for the returning byte.
// Optional feature macro: CQ_READER_CHECKSUM_EN adds a running byte checksum
// output csum over the bytes accepted in the current burst.
module cq_burst_reader #(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rd_start,
    input  logic [CW-1:0]     rd_count,
    cq_burst_reader_if.master bus,
    output logic              busy,
    output logic              done,
`ifdef CQ_READER_CHECKSUM_EN
    output logic [DW-1:0]     csum,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // rd_count of zero encodes the longest burst, 2^CW.
    localparam logic [CW:0] FULL_LEN = {1'b1, {CW{1'b0}}};

    state_t        state;
    logic [CW:0]   issue_rem;    // pops still to issue
    logic [CW:0]   deliver_rem;  // handshakes still to complete
    logic [DW-1:0] buf_mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    buf_count;
    logic          inflight;     // a popped byte arrives on q_data this cycle

    logic [CW:0]   burst_len;
    logic          hs;
    logic [2:0]    occupancy;
    logic          pop;

    assign burst_len      = (rd_count == '0) ? FULL_LEN : {1'b0, rd_count};
    assign bus.dout       = buf_mem[rd_ptr];
    assign bus.dout_valid = (buf_count != 2'd0);
    assign hs             = bus.dout_valid & bus.dout_ready;

    // Slots committed by the end of this cycle: stored bytes plus the byte
    // landing now, minus the byte leaving on this cycle's handshake. A new
    // pop is safe while that stays below two, which keeps one byte per cycle
    // flowing when the consumer is always ready.
    assign occupancy = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, hs};
    assign pop       = (state == RUN) & en & ~bus.q_empty &
                       (issue_rem != '0) & (occupancy < 3'd2);
    assign bus.q_pop = pop;
    assign dbg_state = state;

    // Burst FSM, skid buffer and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            issue_rem   <= '0;
            deliver_rem <= '0;
            buf_mem[0]  <= '0;
            buf_mem[1]  <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            buf_count   <= 2'd0;
            inflight    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef CQ_READER_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            done     <= 1'b0;
            inflight <= pop;

            if (inflight) begin
                buf_mem[wr_ptr] <= bus.q_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (hs) begin
                rd_ptr <= ~rd_ptr;
            end
            buf_count <= buf_count + {1'b0, inflight} - {1'b0, hs};

            case (state)
                IDLE: begin
                    if (rd_start) begin
                        issue_rem   <= burst_len;
                        deliver_rem <= burst_len;
                        busy        <= 1'b1;
                        state       <= RUN;
`ifdef CQ_READER_CHECKSUM_EN
                        csum        <= '0;
`endif
                    end
                end
                RUN: begin
                    if (pop) begin
                        issue_rem <= issue_rem - 1'b1;
                    end
                    if (hs) begin
                        deliver_rem <= deliver_rem - 1'b1;
`ifdef CQ_READER_CHECKSUM_EN
                        csum        <= csum + bus.dout;
`endif
                        if (deliver_rem == {{CW{1'b0}}, 1'b1}) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cq_burst_reader.sv
// tb_cq_burst_reader: drives cq_burst_reader with a queue model whose read
// data returns one clock after each pop, collects accepted stream bytes and
// compares them against the bytes the burst rules say must come out.
module tb_cq_burst_reader;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          rd_start;
    logic [CW-1:0] rd_count;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;
`ifdef CQ_READER_CHECKSUM_EN
    logic [DW-1:0] csum;
`endif

    logic          ready;
    logic [DW-1:0] q_data_r;
    logic [DW-1:0] fifo [$];
    int            fifo_n;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];
    int            hs_cnt;
    int            pop_cnt;
    int            done_cnt;
    int            n_checks;
    int            n_fail;

    logic          pop_s;
    logic          prev_valid;
    logic          prev_ready;
    logic [DW-1:0] prev_dout;

    typedef struct {
        logic [CW-1:0] cnt;
        int            preload;
        int            exp_len;
        int            exp_left;
        int            rnd;
    } vec_t;

    vec_t vecs [6];

    cq_burst_reader_if #(.DW(DW)) bus ();

    assign bus.q_empty    = (fifo_n == 0);
    assign bus.q_data     = q_data_r;
    assign bus.dout_ready = ready;

    cq_burst_reader #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rd_start  (rd_start),
        .rd_count  (rd_count),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
`ifdef CQ_READER_CHECKSUM_EN
        .csum      (csum),
`endif
        .dbg_state (dbg_state)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Queue model: a pop seen before an edge releases the head byte just after it.
    always @(negedge clk) pop_s = bus.q_pop;
    always @(posedge clk) begin
        #1;
        if (pop_s) begin
            if (fifo.size() > 0) q_data_r = fifo.pop_front();
            fifo_n = fifo.size();
            pop_cnt++;
            pop_s = 1'b0;
        end
    end

    // Monitor: records handshakes and done pulses, checks stream stability and pop credit.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", bus.dout_valid, 1);
                check("hold_data", bus.dout, prev_dout);
            end
            if (bus.q_pop)
                check("credit", (pop_cnt - hs_cnt + 1 - ((bus.dout_valid && bus.dout_ready) ? 1 : 0)) <= 2, 1);
            if (bus.dout_valid && bus.dout_ready) begin
                got_q.push_back(bus.dout);
                hs_cnt++;
            end
            if (done) done_cnt++;
            prev_valid = bus.dout_valid;
            prev_ready = bus.dout_ready;
            prev_dout  = bus.dout;
        end
    end

    function automatic int model_len(input logic [CW-1:0] cnt);
        return (cnt == 0) ? (1 << CW) : int'(cnt);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [DW-1:0] b);
        fifo.push_back(b);
        fifo_n = fifo.size();
    endtask

    task automatic clear_fifo();
        fifo.delete();
        fifo_n = 0;
    endtask

    // Expected stream: the first len bytes currently waiting in the queue.
    task automatic start_burst(input logic [CW-1:0] cnt, input int len);
        got_q.delete();
        exp_q.delete();
        hs_cnt   = 0;
        pop_cnt  = 0;
        done_cnt = 0;
        for (int i = 0; i < len && i < fifo.size(); i++) exp_q.push_back(fifo[i]);
        rd_count = cnt;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
    endtask

    task automatic wait_done(input int rnd, input int max_cycles);
        for (int c = 0; c < max_cycles && done_cnt == 0; c++) begin
            if (rnd != 0) begin
                ready = 1'($urandom_range(0, 1));
                en    = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        ready = 1'b1;
        en    = 1'b1;
    endtask

    task automatic finish_burst(input string name, input int len);
        logic [DW-1:0] s;
        repeat (3) step();
        check({name, "_done_once"}, done_cnt, 1);
        check({name, "_busy_low"}, busy, 0);
        check({name, "_pops"}, pop_cnt, len);
        check({name, "_count"}, got_q.size(), len);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({name, "_byte"}, got_q[i], exp_q[i]);
        s = '0;
        foreach (exp_q[i]) s = s + exp_q[i];
`ifdef CQ_READER_CHECKSUM_EN
        check({name, "_csum"}, csum, s);
`else
        if (s != s) n_fail++;
`endif
    endtask

    initial begin
        logic          exp_pop   [5];
        logic          exp_valid [5];
        logic [DW-1:0] exp_dout  [5];
        logic [CW-1:0] cnt;
        int            len;
        int            extra;

        n_checks = 0;
        n_fail   = 0;
        hs_cnt   = 0;
        pop_cnt  = 0;
        done_cnt = 0;
        pop_s    = 1'b0;
        q_data_r = '0;
        fifo_n   = 0;
        rst      = 1'b0;
        en       = 1'b1;
        rd_start = 1'b0;
        rd_count = '0;
        ready    = 1'b1;

        // Reset values
        #3 rst = 1'b1;
        #1;
        check("rst_q_pop", bus.q_pop, 0);
        check("rst_valid", bus.dout_valid, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) step();
        rst = 1'b0;
        step();

        // Table of whole bursts
        vecs[0] = '{cnt: 4'd3,  preload: 3,  exp_len: 3,  exp_left: 0, rnd: 0};
        vecs[1] = '{cnt: 4'd0,  preload: 20, exp_len: 16, exp_left: 4, rnd: 0};
        vecs[2] = '{cnt: 4'd1,  preload: 2,  exp_len: 1,  exp_left: 1, rnd: 1};
        vecs[3] = '{cnt: 4'd15, preload: 15, exp_len: 15, exp_left: 0, rnd: 1};
        vecs[4] = '{cnt: 4'd5,  preload: 8,  exp_len: 5,  exp_left: 3, rnd: 1};
        vecs[5] = '{cnt: 4'd0,  preload: 16, exp_len: 16, exp_left: 0, rnd: 1};
        for (int v = 0; v < 6; v++) begin
            clear_fifo();
            for (int i = 0; i < vecs[v].preload; i++) push(8'($urandom));
            start_burst(vecs[v].cnt, vecs[v].exp_len);
            wait_done(vecs[v].rnd, 300);
            finish_burst("vec", vecs[v].exp_len);
            check("vec_left", fifo_n, vecs[v].exp_left);
        end

        // Cycle-exact 3-byte burst with a rd_start during DONE that must be ignored
        clear_fifo();
        push(8'h11); push(8'h22); push(8'h33);
        ready = 1'b1;
        exp_pop   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_valid = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_dout  = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
        start_burst(4'd3, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t_pop", bus.q_pop, exp_pop[i]);
            check("t_valid", bus.dout_valid, exp_valid[i]);
            if (exp_valid[i]) check("t_dout", bus.dout, exp_dout[i]);
            check("t_busy", busy, 1);
        end
        @(posedge clk);
        #2;
        push(8'h44);
        rd_start = 1'b1;
        @(negedge clk);
        check("t_done", done, 1);
        check("t_done_busy", busy, 0);
        step();
        rd_start = 1'b0;
        @(negedge clk);
        check("t_ignored_busy", busy, 0);
        check("t_ignored_pop", bus.q_pop, 0);
        check("t_done_pulse", done, 0);
        finish_burst("timing", 3);
        check("t_left", fifo_n, 1);

        // Downstream stall with a rd_start while running
        clear_fifo();
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        ready = 1'b0;
        start_burst(4'd4, 4);
        repeat (3) step();
        rd_count = 4'd1;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("stall_pops", pop_cnt, 2);
        check("stall_no_pop", bus.q_pop, 0);
        check("stall_valid", bus.dout_valid, 1);
        check("stall_dout", bus.dout, 8'hA0);
        ready = 1'b1;
        wait_done(0, 50);
        finish_burst("stall", 4);

        // Queue runs dry mid-burst, then refills
        clear_fifo();
        push(8'h03); push(8'h04);
        ready = 1'b1;
        start_burst(4'd4, 2);
        repeat (4) step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("empty_no_pop", bus.q_pop, 0);
            step();
        end
        check("empty_partial", got_q.size(), 2);
        check("empty_busy", busy, 1);
        push(8'h05); push(8'h06);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h06);
        wait_done(0, 50);
        finish_burst("empty", 4);

        // Asynchronous reset mid-burst, then a clean burst
        clear_fifo();
        for (int i = 0; i < 8; i++) push(8'($urandom));
        ready = 1'b0;
        start_burst(4'd8, 8);
        repeat (4) step();
        check("pre_rst_valid", bus.dout_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_pop", bus.q_pop, 0);
        check("arst_valid", bus.dout_valid, 0);
        check("arst_dout", bus.dout, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        step();
        rst   = 1'b0;
        ready = 1'b1;
        step();
        clear_fifo();
        for (int i = 0; i < 3; i++) push(8'($urandom));
        start_burst(4'd3, 3);
        wait_done(0, 50);
        finish_burst("after_rst", 3);

        // Randomized bursts with random ready and enable
        for (int r = 0; r < 10; r++) begin
            cnt   = CW'($urandom_range(0, (1 << CW) - 1));
            len   = model_len(cnt);
            extra = $urandom_range(0, 3);
            clear_fifo();
            for (int i = 0; i < len + extra; i++) push(8'($urandom));
            start_burst(cnt, len);
            wait_done(1, 400);
            finish_burst("rand", len);
            check("rand_left", fifo_n, extra);
        end

`ifdef CQ_READER_CHECKSUM_EN
        // Checksum wraps modulo 2^DW, holds after done, clears at next start
        clear_fifo();
        push(8'hFF); push(8'h02); push(8'h10);
        start_burst(4'd3, 3);
        wait_done(0, 50);
        finish_burst("csum", 3);
        check("csum_value", csum, 8'h11);
        clear_fifo();
        push(8'h01); push(8'h02);
        start_burst(4'd2, 2);
        @(negedge clk);
        check("csum_cleared", csum, 0);
        wait_done(0, 50);
        finish_burst("csum2", 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
